// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues in-order word reads to instruction memory,
// buffers returned words together with their PC and hands them to decode one
// at a time. A taken branch redirects the PC and squashes wrong-path words.
//
// Handshake semantics (all three interfaces): a transfer happens on a rising
// edge where valid && ready are both high; valid never depends on ready of the
// same interface, and payload is held stable while valid && !ready.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // FETCH: normal operation. DRAIN: waiting for wrong-path responses to return.
  typedef enum logic {FETCH, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] drop_q, drop_d;

  // PC of each outstanding request, so returning data can be tagged.
  logic [31:0]   pcq [DEPTH];
  logic [PW-1:0] pcq_wr, pcq_rd;

  // Instruction buffer presented to decode.
  logic [31:0]   buf_pc   [DEPTH];
  logic [31:0]   buf_data [DEPTH];
  logic [PW-1:0] buf_wr, buf_rd;

  logic req_fire, push, pop, has_credit;
  logic unused_redirect_lo;

  assign unused_redirect_lo = ^redirect_pc[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Requests stop once every buffer slot is either filled or promised to an
  // outstanding read, so a response always has somewhere to land.
  assign has_credit     = ({1'b0, inflight_q} + {1'b0, count_q}) < {1'b0, FULL};
  assign imem_req_valid = !rst && (state_q == FETCH) && !redirect_valid && has_credit;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid = !rst && (count_q != '0);
  assign instr       = buf_data[buf_rd];
  assign instr_pc    = buf_pc[buf_rd];
  assign pop         = instr_valid && instr_ready;

  // A response is kept only when nothing is pending to be squashed and no
  // redirect is squashing it this very cycle.
  assign push = imem_resp_valid && (drop_q == '0) && !redirect_valid;

  assign inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
  assign count_d    = redirect_valid ? '0 : (count_q + CW'(push) - CW'(pop));

  // Next-state and squash-count logic; a redirect squashes every word still in flight.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (redirect_valid) begin
      drop_d  = inflight_d;
      state_d = (inflight_d != '0) ? DRAIN : FETCH;
    end else if (imem_resp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
      if (drop_q == CW'(1)) state_d = FETCH;
    end
  end

  // Control state: FSM, PC, counters and queue pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      pcq_wr     <= '0;
      pcq_rd     <= '0;
      buf_wr     <= '0;
      buf_rd     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      if (redirect_valid) pc_q <= {redirect_pc[31:2], 2'b00};
      else if (req_fire)  pc_q <= pc_q + 32'd4;
      if (req_fire)        pcq_wr <= ptr_inc(pcq_wr);
      if (imem_resp_valid) pcq_rd <= ptr_inc(pcq_rd);
      if (redirect_valid) begin
        buf_wr <= '0;
        buf_rd <= '0;
      end else begin
        if (push) buf_wr <= ptr_inc(buf_wr);
        if (pop)  buf_rd <= ptr_inc(buf_rd);
      end
    end
  end

  // Datapath storage: request PCs and buffered words need no reset.
  always_ff @(posedge clk) begin
    if (req_fire) pcq[pcq_wr] <= pc_q;
    if (push) begin
      buf_pc[buf_wr]   <= pcq[pcq_rd];
      buf_data[buf_wr] <= imem_resp_data;
    end
  end

  // The credit scheme must make buffer overflow and orphan responses impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == FULL)));
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
    !(imem_resp_valid && (inflight_q == '0)));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model with adjustable latency, an
// expected-stream scoreboard driven by fetch/redirect rules, and directed plus
// randomized stimulus.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int unsigned DEPTH  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  instr_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Instruction memory contents: a bijective scramble of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]} ^ 32'h0F0F_1234;
  endfunction

  // Memory model: in-order responses, each no earlier than lat cycles after acceptance.
  int          lat = 1;
  int          cyc = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  end

  // Scoreboard: expected architectural stream {pc, word}. It restarts at the
  // reset PC, continues sequentially, and after a redirect continues at the
  // word-aligned target (a word consumed in the redirect cycle still counts).
  logic [63:0] exp_q[$];
  logic [31:0] exp_tail;
  logic [31:0] fetch_pc;
  int          tb_out = 0;
  logic        held_v = 1'b0;
  logic [31:0] held_i, held_pc;
  logic [31:0] first_req[$];

  task automatic refill(input logic [31:0] start);
    logic [31:0] a;
    a = start;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({a, mem_word(a)});
      a += 32'd4;
    end
    exp_tail = a;
  endtask

  // Monitor: samples all interfaces mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      check1("rst_req_valid", imem_req_valid, 1'b0);
      check1("rst_instr_valid", instr_valid, 1'b0);
      pend_addr.delete();
      pend_due.delete();
      tb_out   = 0;
      held_v   = 1'b0;
      fetch_pc = RST_PC;
      first_req.delete();
      refill(RST_PC);
    end else begin
      if (imem_resp_valid) tb_out--;
      if (imem_req_valid && imem_req_ready) begin
        check32("req_addr", imem_req_addr, fetch_pc);
        if (first_req.size() < 4) first_req.push_back(imem_req_addr);
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + lat);
        fetch_pc += 32'd4;
        tb_out++;
      end
      if (tb_out > int'(DEPTH)) begin
        total++;
        bad++;
        $display("FAIL outstanding: got %0d expected <= %0d", tb_out, DEPTH);
      end
      if (redirect_valid) check1("req_in_redirect", imem_req_valid, 1'b0);
      if (held_v) begin
        check1("stall_valid", instr_valid, 1'b1);
        check32("stall_instr", instr, held_i);
        check32("stall_pc", instr_pc, held_pc);
      end
      if (instr_valid && instr_ready) begin
        e = exp_q.pop_front();
        exp_q.push_back({exp_tail, mem_word(exp_tail)});
        exp_tail += 32'd4;
        check32("instr_pc", instr_pc, e[63:32]);
        check32("instr", instr, e[31:0]);
      end
      held_v  = instr_valid && !instr_ready && !redirect_valid;
      held_i  = instr;
      held_pc = instr_pc;
      if (redirect_valid) begin
        refill({redirect_pc[31:2], 2'b00});
        fetch_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  // Stimulus
  initial begin
    bit found;

    // Reset and sequential stream, latency 1, no back-pressure.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("first_cycle_valid", instr_valid, 1'b0);
    check1("first_cycle_req", imem_req_valid, 1'b1);
    @(negedge clk);
    check1("second_cycle_valid", instr_valid, 1'b0);
    @(negedge clk);
    check1("min_latency_valid", instr_valid, 1'b1);
    check32("min_latency_pc", instr_pc, RST_PC);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check1("stream_valid", instr_valid, 1'b1);
    end
    @(posedge clk);
    #2;
    if (first_req.size() != 4) timeout_fail("first_req_count");
    else begin
      check32("wrap_addr0", first_req[0], 32'hFFFF_FFF8);
      check32("wrap_addr1", first_req[1], 32'hFFFF_FFFC);
      check32("wrap_addr2", first_req[2], 32'h0000_0000);
      check32("wrap_addr3", first_req[3], 32'h0000_0004);
    end

    // Decode stalls for 10 cycles: requests must stop, output must hold.
    #1 instr_ready = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check1("stall_req_stopped", imem_req_valid, 1'b0);
    instr_ready = 1'b1;
    repeat (10) @(posedge clk);

    // Latency 3, redirect with words in flight.
    #1 lat = 3;
    repeat (10) @(posedge clk);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #2;
      if (tb_out >= 2) found = 1;
    end
    if (!found) timeout_fail("wait_inflight");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        check32("after_redirect_pc", instr_pc, 32'h0000_0040);
        found = 1;
      end
    end
    if (!found) timeout_fail("after_redirect_valid");

    // Redirect coinciding with a response and a decode handshake.
    lat = 1;
    repeat (10) @(posedge clk);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk);
      #2;
      if (imem_resp_valid && instr_valid) found = 1;
    end
    if (!found) timeout_fail("wait_resp_and_pop");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        check32("unaligned_redirect_addr", imem_req_addr, 32'h0000_0040);
        found = 1;
      end
    end
    if (!found) timeout_fail("redirect_req");
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (instr_valid) begin
        check32("coincident_redirect_pc", instr_pc, 32'h0000_0040);
        found = 1;
      end else @(negedge clk);
    end
    if (!found) timeout_fail("coincident_redirect_valid");

    // Reset with two words buffered and one in flight.
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    instr_ready = 1'b0;
    lat = 3;
    repeat (5) @(posedge clk);
    #2;
    check1("buffered_before_rst", instr_valid, 1'b1);
    check32("buffered_head_pc", instr_pc, RST_PC);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    instr_ready = 1'b1;
    lat = 1;
    @(negedge clk);
    check1("post_rst_valid", instr_valid, 1'b0);
    check1("post_rst_req", imem_req_valid, 1'b1);
    check32("post_rst_addr", imem_req_addr, RST_PC);

    // Randomized traffic: back-pressure, latency changes, random redirects.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      instr_ready    = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if (i % 200 == 0) lat = $urandom_range(1, 4);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = 32'($urandom_range(0, 1023));
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    repeat (20) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
